read_ctrl_stream: RTL and testbench

//  Read-side controller downstream of read_logic_header. It drives rd_char_incr/rd_newline to walk the

---
 rtl/read_ctrl_stream.sv | 154 +++++++++++++++
 tb/tb_read_ctrl_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_ctrl_stream.sv
// Read-side frame streamer: walks the line buffer with rd_char_incr/rd_newline, captures RAM bytes
// after a fixed read latency and emits each frame as a backpressured 8-bit AXI-Stream.
module read_ctrl_stream #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_ready,
  input  logic        tlast_flag,
  input  logic [15:0] body_length,
  input  logic [7:0]  rd_data,
  output logic        rd_char_incr,
  output logic        rd_newline,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        frame_err
);

  localparam int LB_W  = $clog2(LINE_BYTES) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IF_W  = $clog2(RD_LAT + 1);
  localparam int OCC_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STREAM    = 3'd1;
  localparam logic [2:0] S_LINE_WAIT = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_DROP      = 3'd4;

  logic [2:0]        state;
  logic [15:0]       rem_issue;
  logic [LB_W-1:0]   lb;

  // Read pipe: one valid/last bit per cycle of RAM latency
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  logic [IF_W-1:0]   inflight;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic [OCC_W-1:0]  occ;
  logic              issue;
  logic              last_issue;
  logic              drained;
  logic              push;
  logic              pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IF_W'(pipe_vld[i]);
  end

  // Bytes already in the FIFO plus bytes still in the RAM pipe must fit, or a capture would be lost.
  assign occ        = OCC_W'(fifo_cnt) + OCC_W'(inflight);
  assign issue      = (state == S_STREAM) && line_ready && (rem_issue != 16'd0) &&
                      (lb < LB_W'(LINE_BYTES)) && (occ < OCC_W'(FIFO_DEPTH));
  assign last_issue = issue && (rem_issue == 16'd1);
  assign drained    = (inflight == '0);

  assign rd_char_incr = issue;
  assign rd_newline   = (((state == S_LINE_WAIT) || (state == S_DRAIN)) && drained) ||
                        (state == S_DROP);
  assign frame_err    = ((state == S_DRAIN) && drained && !tlast_flag) || (state == S_DROP);

  assign push          = pipe_vld[RD_LAT-1];
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  // Storage is not reset, so the head entry is masked until it holds a valid byte.
  assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : 9'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rem_issue <= '0;
      lb        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line_ready) begin
            rem_issue <= body_length;
            lb        <= '0;
            state     <= (body_length == 16'd0) ? S_DROP : S_STREAM;
          end
        end
        S_STREAM: begin
          if (issue) begin
            rem_issue <= rem_issue - 16'd1;
            lb        <= lb + LB_W'(1);
            if (last_issue)                         state <= S_DRAIN;
            else if (lb == LB_W'(LINE_BYTES - 1))   state <= S_LINE_WAIT;
          end
        end
        S_LINE_WAIT: begin
          // Never release a line while reads from it are still in flight.
          if (drained) begin
            lb    <= '0;
            state <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (drained) state <= S_IDLE;
        end
        S_DROP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // NOTE: the data array has no reset; only pointers and count need one, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pipe_last[RD_LAT-1], rd_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_read_ctrl_stream.sv
// Scoreboard bench for read_ctrl_stream: a line-buffer/RAM model feeds the DUT, expected bytes are
// queued when each frame is offered and compared as the stream delivers them.
module tb_read_ctrl_stream;

  localparam int LINE_BYTES = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line_ready;
  logic        tlast_flag;
  logic [15:0] body_length;
  logic [7:0]  rd_data;
  logic        rd_char_incr;
  logic        rd_newline;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        frame_err;

  read_ctrl_stream #(.RD_LAT(1), .FIFO_DEPTH(4), .LINE_BYTES(LINE_BYTES)) dut (
    .clk(clk), .rst(rst), .line_ready(line_ready), .tlast_flag(tlast_flag),
    .body_length(body_length), .rd_data(rd_data), .rd_char_incr(rd_char_incr),
    .rd_newline(rd_newline), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram(input int line, input int ch);
    return 8'(ch + line * 37);
  endfunction

  // Line-buffer / RAM model state
  int m_line = 0, m_char = 0, pending = 0, gap_cnt = 0, next_gap = 0;
  bit rand_ready = 0;

  // Monitor state
  int cyc = 0, lr_cyc = -1, tv_cyc = -1;
  int incr_cnt = 0, nl_cnt = 0, err_cnt = 0, pop_cnt = 0, exp_nl = 0, exp_err = 0;
  int nl_incr[$];
  bit tv_seen = 0, prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : model
    logic s_incr, s_nl;
    rd_data = '0; line_ready = 0; m_axis_tready = 1;
    forever begin
      @(negedge clk);
      s_incr = rd_char_incr;
      s_nl   = rd_newline;
      @(posedge clk);
      #1;
      if (!rst) begin
        m_line = 0; m_char = 0; pending = 0; gap_cnt = 0; line_ready = 0;
      end else begin
        if (s_incr) begin
          rd_data = ram(m_line, m_char);
          m_char++;
        end
        if (s_nl) begin
          m_line++; m_char = 0;
          if (pending > 0) pending--;
          gap_cnt = next_gap;
        end else if (gap_cnt > 0) gap_cnt--;
        line_ready = (pending > 0) && (gap_cnt == 0);
      end
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) prev_stall = 0;
      else begin
        if (rd_char_incr) incr_cnt++;
        if (rd_newline) begin
          nl_cnt++;
          nl_incr.push_back(incr_cnt);
          check("incr_nl_exclusive", rd_char_incr, 0);
        end
        if (frame_err) begin
          err_cnt++;
          check("err_at_newline", rd_newline, 1);
        end
        if (line_ready && lr_cyc < 0) lr_cyc = cyc;
        if (m_axis_tvalid) begin
          tv_seen = 1;
          if (tv_cyc < 0) tv_cyc = cyc;
        end
        if (prev_stall) begin
          check("stall_tvalid", m_axis_tvalid, 1);
          check("stall_tdata", m_axis_tdata, prev_data);
          check("stall_tlast", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          pop_cnt++;
          if (sb.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            check("tdata", m_axis_tdata, e.data);
            check("tlast", m_axis_tlast, e.last);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  task automatic start_frame(input int len, input bit tl, input int lines, input int gap);
    exp_t e;
    @(negedge clk);
    incr_cnt = 0; pop_cnt = 0; lr_cyc = -1; tv_cyc = -1; tv_seen = 0;
    nl_incr.delete();
    body_length = 16'(len);
    tlast_flag  = tl;
    next_gap    = gap;
    gap_cnt     = 0;
    for (int k = 0; k < len; k++) begin
      e.data = ram(m_line + k / LINE_BYTES, k % LINE_BYTES);
      e.last = (k == len - 1);
      sb.push_back(e);
    end
    exp_nl  += lines;
    exp_err += ((len == 0) || !tl) ? 1 : 0;
    pending = lines;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(nl_cnt == exp_nl && sb.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check({name, "_newlines"}, nl_cnt, exp_nl);
    check({name, "_frame_err"}, err_cnt, exp_err);
    check({name, "_tvalid_idle"}, m_axis_tvalid, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_incr"}, rd_char_incr, 0);
    check({name, "_newline"}, rd_newline, 0);
    check({name, "_tvalid"}, m_axis_tvalid, 0);
    check({name, "_tdata"}, m_axis_tdata, 0);
    check({name, "_tlast"}, m_axis_tlast, 0);
    check({name, "_err"}, frame_err, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    body_length = '0; tlast_flag = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1;
    repeat (2) @(negedge clk);

    // 1: single-line frame, full throughput, latency from line_ready
    start_frame(64, 1, 1, 0);
    wait_done("t1", 500);
    check("t1_incr", incr_cnt, 64);
    check("t1_pops", pop_cnt, 64);
    check("t1_latency", tv_cyc - lr_cyc, 3);

    // 2: random backpressure
    rand_ready = 1;
    start_frame(200, 1, 1, 0);
    wait_done("t2", 3000);
    rand_ready = 0;
    check("t2_pops", pop_cnt, 200);

    // 3: frame spanning two lines, second line ready late
    start_frame(1000, 1, 2, 20);
    wait_done("t3", 5000);
    check("t3_incr", incr_cnt, 1000);
    check("t3_nl_count", nl_incr.size(), 2);
    if (nl_incr.size() == 2) begin
      check("t3_first_line_bytes", nl_incr[0], 512);
      check("t3_second_line_bytes", nl_incr[1], 1000);
    end

    // 4: zero-length frame is dropped
    start_frame(0, 1, 1, 0);
    wait_done("t4", 200);
    check("t4_no_stream", tv_seen, 0);
    check("t4_incr", incr_cnt, 0);

    // 5: missing tlast_flag on final line
    start_frame(10, 0, 1, 0);
    wait_done("t5", 300);
    check("t5_pops", pop_cnt, 10);

    // 6: reset mid-frame, then a clean frame
    start_frame(64, 1, 1, 0);
    n = 0;
    while (pop_cnt < 30 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_byte30", (n < 500) ? 1 : 0, 1);
    @(posedge clk);
    #3 rst = 0;
    #1 check_outputs_zero("t6_async");
    sb.delete();
    repeat (2) @(negedge clk);
    nl_cnt = 0; exp_nl = 0; err_cnt = 0; exp_err = 0;
    rst = 1;
    @(negedge clk);
    check("t6_fifo_empty", m_axis_tvalid, 0);
    start_frame(64, 1, 1, 0);
    wait_done("t6b", 500);
    check("t6b_pops", pop_cnt, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
